// File: rtl/rx_word_assembler.sv
// Packs consecutive UART bytes into little-endian words and offers them on a valid/ready
// handshake. It flags bytes dropped while a word is held and discards stale partial words.
module rx_word_assembler #(
   parameter int DATA_BITS      = 8,
   parameter int BYTES_PER_WORD = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                                  i_clock,
   input  logic                                  i_reset,
   input  logic                                  i_rx_done_tick,
   input  logic [DATA_BITS-1:0]                  i_rx_data,
   input  logic                                  i_ready,
   input  logic                                  i_clear,
   output logic                                  o_valid,
   output logic [DATA_BITS*BYTES_PER_WORD-1:0]   o_word,
   output logic [$clog2(BYTES_PER_WORD+1)-1:0]   o_byte_count,
   output logic                                  o_overflow,
   output logic                                  o_timeout
);

   localparam int CW = $clog2(BYTES_PER_WORD + 1);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int WW = DATA_BITS * BYTES_PER_WORD;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0] LAST_LANE  = CW'(BYTES_PER_WORD - 1);
   localparam logic [TW-1:0] IDLE_LIMIT = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [WW-1:0] word_q, word_d;
   logic [TW-1:0] idle_q, idle_d;
   logic          ovf_q, ovf_d;
   logic          tmo_q, tmo_d;

   // State and datapath registers.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_COLLECT;
         count_q <= '0;
         word_q  <= '0;
         idle_q  <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         word_q  <= word_d;
         idle_q  <= idle_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state logic; a clear overrides every other event, including a same-cycle byte.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      word_d  = word_q;
      idle_d  = idle_q;
      ovf_d   = ovf_q;
      tmo_d   = 1'b0;
      if (i_clear) begin
         state_d = ST_COLLECT;
         count_d = '0;
         idle_d  = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (i_rx_done_tick) begin
                  for (int l = 0; l < BYTES_PER_WORD; l++) begin
                     if (count_q == CW'(l)) begin
                        word_d[l*DATA_BITS +: DATA_BITS] = i_rx_data;
                     end else begin
                        word_d[l*DATA_BITS +: DATA_BITS] = word_q[l*DATA_BITS +: DATA_BITS];
                     end
                  end
                  idle_d = '0;
                  if (count_q == LAST_LANE) begin
                     count_d = '0;
                     state_d = ST_HOLD;
                  end else begin
                     count_d = count_q + CW'(1);
                  end
               end else if (TIMEOUT_EN && (count_q != '0)) begin
                  if (idle_q == IDLE_LIMIT) begin
                     count_d = '0;
                     idle_d  = '0;
                     tmo_d   = 1'b1;
                  end else begin
                     idle_d = idle_q + TW'(1);
                  end
               end else begin
                  idle_d = '0;
               end
            end
            ST_HOLD: begin
               // A byte arriving with the transfer becomes lane 0 of the next word.
               if (i_ready) begin
                  state_d = ST_COLLECT;
                  if (i_rx_done_tick) begin
                     word_d[DATA_BITS-1:0] = i_rx_data;
                     count_d = CW'(1);
                     idle_d  = '0;
                  end else begin
                     count_d = '0;
                  end
               end else if (i_rx_done_tick) begin
                  ovf_d = 1'b1;
               end else begin
                  ovf_d = ovf_q;
               end
            end
            default: begin
               state_d = ST_COLLECT;
               count_d = '0;
               idle_d  = '0;
            end
         endcase
      end
   end

   assign o_valid      = (state_q == ST_HOLD);
   assign o_word       = word_q;
   assign o_byte_count = count_q;
   assign o_overflow   = ovf_q;
   assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Directed and randomized checks of rx_word_assembler against a queue-based model.
module tb_rx_word_assembler;

   localparam int DB  = 8;
   localparam int BPW = 4;
   localparam int TO  = 16;

   logic          i_clock;
   logic          i_reset;
   logic          i_rx_done_tick;
   logic [DB-1:0] i_rx_data;
   logic          i_ready;
   logic          i_clear;
   logic          o_valid;
   logic [31:0]   o_word;
   logic [2:0]    o_byte_count;
   logic          o_overflow;
   logic          o_timeout;

   int compares = 0;
   int fails    = 0;

   // Reference model: pending bytes as a queue, a held word, flags and an idle age.
   logic [7:0]  m_part[$];
   logic [31:0] m_held;
   bit          m_valid;
   bit          m_ovf;
   bit          m_tmo;
   int          m_idle;

   rx_word_assembler #(.DATA_BITS(DB), .BYTES_PER_WORD(BPW), .TIMEOUT_CYCLES(TO)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_rx_done_tick(i_rx_done_tick),
      .i_rx_data(i_rx_data), .i_ready(i_ready), .i_clear(i_clear),
      .o_valid(o_valid), .o_word(o_word), .o_byte_count(o_byte_count),
      .o_overflow(o_overflow), .o_timeout(o_timeout)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_part.delete();
      m_held  = 32'h0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_tmo   = 1'b0;
      m_idle  = 0;
   endtask

   task automatic model_step(input bit st, input logic [7:0] d, input bit rdy, input bit clr);
      bit tmo_n;
      tmo_n = 1'b0;
      if (clr) begin
         m_part.delete();
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_idle  = 0;
      end else if (m_valid) begin
         if (rdy) begin
            m_valid = 1'b0;
            if (st) begin
               m_part.push_back(d);
               m_idle = 0;
            end
         end else if (st) begin
            m_ovf = 1'b1;
         end
      end else if (st) begin
         m_part.push_back(d);
         m_idle = 0;
         if (m_part.size() == BPW) begin
            for (int i = 0; i < BPW; i++) m_held[i*8 +: 8] = m_part[i];
            m_valid = 1'b1;
            m_part.delete();
         end
      end else if (m_part.size() > 0) begin
         m_idle++;
         if (m_idle == TO) begin
            m_part.delete();
            m_idle = 0;
            tmo_n  = 1'b1;
         end
      end
      m_tmo = tmo_n;
   endtask

   task automatic check_all();
      chk("valid", {31'h0, o_valid}, {31'h0, m_valid});
      chk("count", {29'h0, o_byte_count}, 32'(m_part.size()));
      chk("overflow", {31'h0, o_overflow}, {31'h0, m_ovf});
      chk("timeout", {31'h0, o_timeout}, {31'h0, m_tmo});
      if (m_valid) chk("word", o_word, m_held);
   endtask

   task automatic cyc();
      model_step(i_rx_done_tick, i_rx_data, i_ready, i_clear);
      @(posedge i_clock);
      #1;
      check_all();
   endtask

   task automatic send(input logic [7:0] d);
      i_rx_done_tick = 1'b1;
      i_rx_data      = d;
      cyc();
      i_rx_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, {31'h0, o_valid}, 32'h0);
      chk({tag, "_word"}, o_word, 32'h0);
      chk({tag, "_count"}, {29'h0, o_byte_count}, 32'h0);
      chk({tag, "_ovf"}, {31'h0, o_overflow}, 32'h0);
      chk({tag, "_tmo"}, {31'h0, o_timeout}, 32'h0);
   endtask

   initial begin
      int gap;
      i_reset = 1'b1; i_rx_done_tick = 1'b0; i_rx_data = 8'h00;
      i_ready = 1'b0; i_clear = 1'b0;
      model_reset();
      @(posedge i_clock); @(posedge i_clock); #1;
      chk_all_zero("reset");
      #3 i_reset = 1'b0;

      // 1: basic word with consumer ready
      i_ready = 1'b1;
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      chk("t1_valid", {31'h0, o_valid}, 32'h1);
      chk("t1_word", o_word, 32'h12345678);
      cyc();
      chk("t1_drop", {31'h0, o_valid}, 32'h0);
      chk("t1_count", {29'h0, o_byte_count}, 32'h0);

      // 2: overflow while held
      i_ready = 1'b0;
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      send(8'h99);
      chk("t2_word", o_word, 32'hDDCCBBAA);
      chk("t2_ovf", {31'h0, o_overflow}, 32'h1);
      i_ready = 1'b1;
      cyc();
      chk("t2_xfer", {31'h0, o_valid}, 32'h0);
      chk("t2_ovf_sticky", {31'h0, o_overflow}, 32'h1);
      idle(3);

      // 3: byte concurrent with transfer starts the next word
      i_ready = 1'b0;
      send(8'h10); send(8'h20); send(8'h30); send(8'h40);
      i_ready = 1'b1;
      send(8'hEF);
      chk("t3_count", {29'h0, o_byte_count}, 32'h1);
      i_ready = 1'b0;
      send(8'h01); send(8'h02); send(8'h03);
      chk("t3_word", o_word, 32'h030201EF);

      // 6: clear while held with overflow set
      send(8'h55);
      chk("t6_pre_ovf", {31'h0, o_overflow}, 32'h1);
      i_clear = 1'b1;
      cyc();
      i_clear = 1'b0;
      chk("t6_valid", {31'h0, o_valid}, 32'h0);
      chk("t6_ovf", {31'h0, o_overflow}, 32'h0);
      chk("t6_count", {29'h0, o_byte_count}, 32'h0);

      // 4: timeout of a partial word, then a strobe that beats it
      i_ready = 1'b1;
      send(8'h11); send(8'h22);
      idle(15);
      chk("t4_no_tmo_yet", {31'h0, o_timeout}, 32'h0);
      cyc();
      chk("t4_tmo", {31'h0, o_timeout}, 32'h1);
      chk("t4_count", {29'h0, o_byte_count}, 32'h0);
      cyc();
      chk("t4_tmo_pulse", {31'h0, o_timeout}, 32'h0);
      send(8'h11); send(8'h22);
      idle(15);
      send(8'h33);
      chk("t4_win_tmo", {31'h0, o_timeout}, 32'h0);
      chk("t4_win_count", {29'h0, o_byte_count}, 32'h3);
      i_clear = 1'b1; cyc(); i_clear = 1'b0;

      // 5: asynchronous reset mid-word
      send(8'hA1); send(8'hA2);
      #2 i_reset = 1'b1;
      #1;
      chk_all_zero("areset");
      model_reset();
      @(posedge i_clock);
      #3 i_reset = 1'b0;
      send(8'hC4); send(8'hC3); send(8'hC2); send(8'hC1);
      chk("t5_word", o_word, 32'hC1C2C3C4);
      cyc();

      // Randomized traffic against the model
      gap = 0;
      for (int n = 0; n < 800; n++) begin
         if (gap > 0) begin
            gap--;
            i_rx_done_tick = 1'b0;
         end else begin
            i_rx_done_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 30) == 0) gap = $urandom_range(10, 22);
         end
         i_rx_data = 8'($urandom);
         i_ready   = ($urandom_range(0, 3) != 0);
         i_clear   = ($urandom_range(0, 80) == 0);
         cyc();
      end
      i_rx_done_tick = 1'b0;
      i_clear = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
